// File: rtl/peripheral_mult_seq_pkg.sv
// Shared constants for the memory-mapped sequential multiplier:
// register offsets, CTRL/STATUS bit positions and FSM state encoding.
package pkg_periph_mult;

    // Register offsets, indexed by addr[4:2]
    localparam logic [2:0] REG_OPA    = 3'd0;
    localparam logic [2:0] REG_OPB    = 3'd1;
    localparam logic [2:0] REG_CTRL   = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;
    localparam logic [2:0] REG_RES_LO = 3'd4;
    localparam logic [2:0] REG_RES_HI = 3'd5;

    // CTRL bits
    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_SIGNED = 1;
    localparam int unsigned CTRL_IE     = 2;

    // STATUS bits
    localparam int unsigned STATUS_BUSY = 0;
    localparam int unsigned STATUS_DONE = 1;
    localparam int unsigned STATUS_ERR  = 2;

    // FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

endpackage

// File: rtl/peripheral_mult_seq_core.sv
// Shift-add multiplier core: IDLE -> LOAD -> RUN (WIDTH cycles) -> FIX.
// Signed mode multiplies magnitudes and negates the product in FIX.
module mult_seq_core
    import pkg_periph_mult::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done_pulse,
    output logic [2*WIDTH-1:0]   p
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]           state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;      // operand B snapshot, then shifting multiplier
    logic                 sgn_q, sgn_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [WIDTH-1:0]     mag_a, mag_b;

    // Operand magnitudes; -2^(W-1) maps to 2^(W-1), which still fits unsigned
    always_comb begin
        mag_a = (sgn_q && a_q[WIDTH-1]) ? (~a_q + WIDTH'(1)) : a_q;
        mag_b = (sgn_q && b_q[WIDTH-1]) ? (~b_q + WIDTH'(1)) : b_q;
    end

    // Next-state logic for FSM and datapath
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        neg_d   = neg_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sgn_d   = is_signed;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                mcand_d = {{WIDTH{1'b0}}, mag_a};
                b_d     = mag_b;
                neg_d   = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                acc_d   = '0;
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (b_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d = {mcand_q[2*WIDTH-2:0], 1'b0};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_FIX: begin
                p_d     = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            neg_q   <= 1'b0;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            neg_q   <= neg_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign done_pulse = (state_q == ST_FIX);
    assign p          = p_q;

endmodule

// File: rtl/peripheral_mult_seq.sv
// Memory-mapped sequential multiplier: register file, address decode,
// status flags and level interrupt around mult_seq_core.
module peripheral_mult_seq
    import pkg_periph_mult::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter bit          IRQ_EN_RST = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] d_in,
    input  logic        cs,
    input  logic [4:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] d_out,
    output logic        irq
);

    logic [WIDTH-1:0]   opa_q, opb_q;
    logic               signed_q, ie_q, done_q, err_q;
    logic               pend_signed_q, res_signed_q;
    logic [31:0]        d_out_q;
    logic [31:0]        rdata;
    logic [2:0]         sel;
    logic               wr_en, rd_en, start_req, start_ok, err_set, status_rd;
    logic               done_now, err_now;
    logic               busy, done_pulse;
    logic [2*WIDTH-1:0] p;
    logic [63:0]        p_zext, p_ext;
    logic               unused_ok;

    assign sel       = addr[4:2];
    assign wr_en     = cs & wr;
    assign rd_en     = cs & rd;
    assign start_req = wr_en && (sel == REG_CTRL) && d_in[CTRL_START];
    // A START landing in FIX still sees busy=1, so it is rejected as an error
    assign start_ok  = start_req & ~busy;
    assign err_set   = start_req & busy;
    assign status_rd = rd_en && (sel == REG_STATUS);
    // A read coinciding with a completion reports it and still clears it
    assign done_now  = done_q | done_pulse;
    assign err_now   = err_q | err_set;
    assign unused_ok = ^{d_in, addr[1:0]};

    mult_seq_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .start      (start_ok),
        .is_signed  (d_in[CTRL_SIGNED]),
        .a          (opa_q),
        .b          (opb_q),
        .busy       (busy),
        .done_pulse (done_pulse),
        .p          (p)
    );

    // Product extended to 64 bits according to the mode it was computed in
    always_comb begin
        p_zext = 64'(p);
        p_ext  = res_signed_q ? 64'($signed(p)) : p_zext;
    end

    // Read-data mux, sampled from pre-write register values
    always_comb begin
        rdata = '0;
        case (sel)
            REG_OPA:    rdata = 32'(opa_q);
            REG_OPB:    rdata = 32'(opb_q);
            REG_CTRL:   rdata = {29'b0, ie_q, signed_q, 1'b0};
            REG_STATUS: rdata = {29'b0, err_now, done_now, busy};
            REG_RES_LO: rdata = p_zext[31:0];
            REG_RES_HI: rdata = p_ext[63:32];
            default:    rdata = '0;
        endcase
    end

    // Register file, status flags and registered read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opa_q         <= '0;
            opb_q         <= '0;
            signed_q      <= 1'b0;
            ie_q          <= IRQ_EN_RST;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            pend_signed_q <= 1'b0;
            res_signed_q  <= 1'b0;
            d_out_q       <= '0;
        end else begin
            if (rd_en) begin
                d_out_q <= rdata;
            end
            if (wr_en) begin
                case (sel)
                    REG_OPA:  opa_q <= d_in[WIDTH-1:0];
                    REG_OPB:  opb_q <= d_in[WIDTH-1:0];
                    REG_CTRL: begin
                        signed_q <= d_in[CTRL_SIGNED];
                        ie_q     <= d_in[CTRL_IE];
                    end
                    default: ;
                endcase
            end
            if (start_ok) begin
                pend_signed_q <= d_in[CTRL_SIGNED];
            end
            if (done_pulse) begin
                res_signed_q <= pend_signed_q;
            end
            done_q <= status_rd ? 1'b0 : done_now;
            err_q  <= status_rd ? 1'b0 : err_now;
        end
    end

    assign d_out = d_out_q;
    assign irq   = done_q & ie_q;

endmodule

// File: tb/tb_peripheral_mult_seq.sv
// Directed bench for peripheral_mult_seq: vector table for products,
// hand-written sequences for busy timing, status/irq, errors and reset.
module tb_peripheral_mult_seq;

    logic        clk = 1'b0;
    logic        reset, cs, rd, wr, sel32;
    logic [4:0]  addr;
    logic [31:0] d_in;
    logic [31:0] d_out16, d_out32;
    logic        irq16, irq32;
    logic        cs16, cs32;
    int          total, bad;

    always #5 clk = ~clk;

    assign cs16 = cs & ~sel32;
    assign cs32 = cs & sel32;

    peripheral_mult_seq #(.WIDTH(16), .IRQ_EN_RST(1'b0)) dut (
        .clk(clk), .reset(reset), .d_in(d_in), .cs(cs16), .addr(addr),
        .rd(rd), .wr(wr), .d_out(d_out16), .irq(irq16)
    );

    peripheral_mult_seq #(.WIDTH(32), .IRQ_EN_RST(1'b0)) dut32 (
        .clk(clk), .reset(reset), .d_in(d_in), .cs(cs32), .addr(addr),
        .rd(rd), .wr(wr), .d_out(d_out32), .irq(irq32)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, exp);
        end
    endtask

    // All bus tasks start just after a negedge and return one negedge later
    task automatic bus_wr(input logic [2:0] r, input logic [31:0] d);
        addr = {r, 2'b00}; d_in = d; cs = 1'b1; wr = 1'b1;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] r, output logic [31:0] d);
        addr = {r, 2'b00}; cs = 1'b1; rd = 1'b1;
        @(negedge clk);
        d = sel32 ? d_out32 : d_out16;
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [2:0] r, input logic [31:0] exp);
        logic [31:0] v;
        bus_rd(r, v);
        check(name, v, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input int wait_cycles);
        bus_wr(3'd0, a);
        bus_wr(3'd1, b);
        bus_wr(3'd2, {30'b0, sgn, 1'b1});
        idle(wait_cycles);
    endtask

    // Polls STATUS every cycle, counting samples with BUSY set
    task automatic busy_count(input int limit, output int cnt, output logic [31:0] last_busy,
                              output logic [31:0] after);
        logic [31:0] s;
        addr = {3'd3, 2'b00}; cs = 1'b1; rd = 1'b1;
        cnt = 0; last_busy = '0; after = '1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            s = sel32 ? d_out32 : d_out16;
            if (s[0]) begin
                cnt++;
                last_busy = s;
            end else begin
                after = s;
                break;
            end
        end
        cs = 1'b0; rd = 1'b0;
    endtask

    initial begin
        int          cnt;
        logic [31:0] lastb, aft, v;

        total = 0; bad = 0;
        reset = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0; sel32 = 1'b0;
        addr = '0; d_in = '0;

        vecs[0] = '{32'h1234, 32'h5678, 1'b0, 32'h06260060, 32'h0};
        vecs[1] = '{32'hFFFD, 32'h0005, 1'b1, 32'hFFFFFFF1, 32'hFFFFFFFF};
        vecs[2] = '{32'h8000, 32'h8000, 1'b1, 32'h40000000, 32'h0};
        vecs[3] = '{32'hFFFF, 32'hFFFF, 1'b0, 32'hFFFE0001, 32'h0};
        vecs[4] = '{32'hFFFF, 32'hFFFF, 1'b1, 32'h00000001, 32'h0};
        vecs[5] = '{32'h0000, 32'h1234, 1'b0, 32'h0, 32'h0};
        vecs[6] = '{32'h8000, 32'h0001, 1'b1, 32'hFFFF8000, 32'hFFFFFFFF};
        vecs[7] = '{32'h7FFF, 32'h8000, 1'b1, 32'hC0008000, 32'hFFFFFFFF};
        vecs[8] = '{32'hFFFF, 32'h0002, 1'b1, 32'hFFFFFFFE, 32'hFFFFFFFF};
        vecs[9] = '{32'h8000, 32'h8000, 1'b0, 32'h40000000, 32'h0};

        idle(2);
        reset = 1'b1;
        idle(1);

        // Reset state
        for (int r = 0; r < 8; r++) rd_chk("reset_reg", 3'(r), 32'h0);
        check("reset_irq", {31'b0, irq16}, 32'h0);

        // Operand masking, CTRL readback, read+write returns pre-write value
        bus_wr(3'd0, 32'hABCD1234);
        rd_chk("opa_mask", 3'd0, 32'h1234);
        addr = 5'd0; d_in = 32'h2222; cs = 1'b1; rd = 1'b1; wr = 1'b1;
        @(negedge clk);
        check("rdwr_old", d_out16, 32'h1234);
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
        rd_chk("rdwr_new", 3'd0, 32'h2222);
        bus_wr(3'd2, 32'h6);
        rd_chk("ctrl_rb", 3'd2, 32'h6);
        bus_wr(3'd2, 32'h0);
        bus_wr(3'd6, 32'hFFFFFFFF);
        rd_chk("reg6_zero", 3'd6, 32'h0);

        // Busy duration; last busy sample coincides with DONE, which then stays cleared
        bus_wr(3'd0, 32'h1234);
        bus_wr(3'd1, 32'h5678);
        bus_wr(3'd2, 32'h1);
        busy_count(40, cnt, lastb, aft);
        check("busy_cycles16", 32'(cnt), 32'd18);
        check("status_coincide", lastb, 32'h3);
        check("status_after_clr", aft, 32'h0);
        rd_chk("busy_res_lo", 3'd4, 32'h06260060);
        rd_chk("busy_res_hi", 3'd5, 32'h0);

        // Product table
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, 18);
            rd_chk("vec_status", 3'd3, 32'h2);
            rd_chk("vec_res_lo", 3'd4, vecs[i].lo);
            rd_chk("vec_res_hi", 3'd5, vecs[i].hi);
        end

        // irq, snapshot against OPA rewrite, START while busy
        bus_wr(3'd2, 32'h4);
        bus_wr(3'd0, 32'h3);
        bus_wr(3'd1, 32'h5);
        bus_wr(3'd2, 32'h5);
        bus_wr(3'd0, 32'h7);
        bus_wr(3'd2, 32'h5);
        idle(15);
        check("irq_before_done", {31'b0, irq16}, 32'h0);
        idle(1);
        check("irq_with_done", {31'b0, irq16}, 32'h1);
        rd_chk("status_done_err", 3'd3, 32'h6);
        check("irq_after_read", {31'b0, irq16}, 32'h0);
        rd_chk("snapshot_res", 3'd4, 32'd15);
        rd_chk("opa_while_busy", 3'd0, 32'h7);
        rd_chk("status_cleared", 3'd3, 32'h0);
        bus_wr(3'd2, 32'h0);

        // START on the completion edge is rejected
        bus_wr(3'd0, 32'h2);
        bus_wr(3'd1, 32'h3);
        bus_wr(3'd2, 32'h1);
        idle(17);
        bus_wr(3'd2, 32'h1);
        rd_chk("start_at_fix", 3'd3, 32'h6);
        rd_chk("start_at_fix_res", 3'd4, 32'd6);

        // Reset mid-RUN, then a fresh operation
        bus_wr(3'd0, 32'h1234);
        bus_wr(3'd1, 32'h5678);
        bus_wr(3'd2, 32'h5);
        idle(5);
        #2 reset = 1'b0;
        idle(1);
        reset = 1'b1;
        idle(1);
        check("rst_mid_dout", d_out16, 32'h0);
        for (int r = 0; r < 8; r++) rd_chk("rst_mid_reg", 3'(r), 32'h0);
        check("rst_mid_irq", {31'b0, irq16}, 32'h0);
        idle(20);
        rd_chk("rst_no_late_done", 3'd3, 32'h0);
        run_op(32'h1234, 32'h5678, 1'b0, 18);
        rd_chk("post_rst_status", 3'd3, 32'h2);
        rd_chk("post_rst_lo", 3'd4, 32'h06260060);
        rd_chk("post_rst_hi", 3'd5, 32'h0);

        // WIDTH=32 instance
        sel32 = 1'b1;
        bus_wr(3'd0, 32'hFFFFFFFF);
        bus_wr(3'd1, 32'h2);
        bus_wr(3'd2, 32'h1);
        busy_count(50, cnt, lastb, aft);
        check("busy_cycles32", 32'(cnt), 32'd34);
        rd_chk("w32_lo", 3'd4, 32'hFFFFFFFE);
        rd_chk("w32_hi", 3'd5, 32'h1);
        run_op(32'hFFFFFFFF, 32'h2, 1'b1, 34);
        rd_chk("w32s_status", 3'd3, 32'h2);
        rd_chk("w32s_lo", 3'd4, 32'hFFFFFFFE);
        rd_chk("w32s_hi", 3'd5, 32'hFFFFFFFF);
        run_op(32'h80000000, 32'h80000000, 1'b1, 34);
        rd_chk("w32min_lo", 3'd4, 32'h0);
        rd_chk("w32min_hi", 3'd5, 32'h40000000);
        sel32 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "timeout");
    end

endmodule
